// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo pose ramper: FSM state encoding,
// default home angle and the packed-angle slice helper.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MOVE = 2'd2
  } servo_state_t;

  localparam int HOME_ANGLE_DEF = 128;

  // LSB position of channel k inside a packed vector of w-bit angles.
  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/servo_ch_ramp.sv
// One servo channel: holds target and current angle, steps the angle toward
// the target by at most `step` on each tick without overshoot or wrap.
module servo_ch_ramp #(
  parameter int ANGLE_W    = 8,
  parameter int STEP_W     = 4,
  parameter int HOME_ANGLE = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [STEP_W-1:0]  step,
  input  logic [ANGLE_W-1:0] target,
  input  logic               load,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target
);

  logic [ANGLE_W-1:0]        tgt_q;
  logic [ANGLE_W-1:0]        ang_q;
  logic [ANGLE_W-1:0]        ang_nxt;
  logic signed [ANGLE_W:0]   diff;
  logic [ANGLE_W:0]          mag;
  logic [ANGLE_W:0]          step_ext;
  logic [ANGLE_W:0]          delta;

  // Largest move allowed this tick: the step, limited to the remaining distance.
  function automatic logic [ANGLE_W:0] sat_step(input logic [ANGLE_W:0] s,
                                                input logic [ANGLE_W:0] m);
    return (s < m) ? s : m;
  endfunction

  always_comb begin
    diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, ang_q});
    mag      = diff[ANGLE_W] ? $unsigned(-diff) : $unsigned(diff);
    step_ext = {{(ANGLE_W + 1 - STEP_W){1'b0}}, step};
    delta    = sat_step(step_ext, mag);
    ang_nxt  = diff[ANGLE_W] ? (ang_q - delta[ANGLE_W-1:0])
                             : (ang_q + delta[ANGLE_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q <= ANGLE_W'(HOME_ANGLE);
      ang_q <= ANGLE_W'(HOME_ANGLE);
    end else begin
      if (load) tgt_q <= target;
      if (tick) ang_q <= ang_nxt;
    end
  end

  assign angle     = ang_q;
  assign at_target = (ang_q == tgt_q);

endmodule

// File: rtl/servo_pose_ramper.sv
// N-channel servo trajectory controller: pose table, command FSM and ramp tick.
// Optional build macro SERVO_LIMIT_EN clamps loaded targets and drives limit_hit.
module servo_pose_ramper
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ANGLE_W     = 8,
  parameter int NUM_POSES   = 8,
  parameter int HOME_ANGLE  = HOME_ANGLE_DEF,
  parameter int RAMP_PERIOD = 65536,
  parameter int STEP_W      = 4,
  parameter int ANGLE_MIN   = 16,
  parameter int ANGLE_MAX   = 240
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_POSES)-1:0]  cmd_pose,
  input  logic [STEP_W-1:0]             cmd_step,
  input  logic                          tbl_we,
  input  logic [$clog2(NUM_POSES)-1:0]  tbl_pose,
  input  logic [$clog2(NUM_CH)-1:0]     tbl_ch,
  input  logic [ANGLE_W-1:0]            tbl_angle,
  output logic [NUM_CH*ANGLE_W-1:0]     angle,
  output logic                          busy,
  output logic                          done,
  output logic                          limit_hit
);

  localparam int POSE_W = $clog2(NUM_POSES);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(RAMP_PERIOD);

  servo_state_t       state, state_nxt;
  logic [POSE_W-1:0]  pose_q;
  logic [STEP_W-1:0]  step_q;
  logic [CH_W-1:0]    idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tick;
  logic               move_tick;
  logic               accept;
  logic [NUM_CH-1:0]  at_tgt;
  logic [ANGLE_W-1:0] rd_val;
  logic [ANGLE_W-1:0] ld_val;
  logic [ANGLE_W-1:0] tbl_q [NUM_POSES][NUM_CH];

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    if (a < ANGLE_W'(ANGLE_MIN)) return ANGLE_W'(ANGLE_MIN);
    if (a > ANGLE_W'(ANGLE_MAX)) return ANGLE_W'(ANGLE_MAX);
    return a;
  endfunction

  assign cmd_ready = (state != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (cnt_q == CNT_W'(RAMP_PERIOD - 1));
  assign move_tick = tick && (state == ST_MOVE);
  // Table read happens before this cycle's write lands, so LOAD sees the old entry.
  assign rd_val    = tbl_q[pose_q][idx_q];

`ifdef SERVO_LIMIT_EN
  assign ld_val = clamp_angle(rd_val);

  always_ff @(posedge clk) begin
    if (rst)                                         limit_hit <= 1'b0;
    else if (state == ST_LOAD && ld_val != rd_val)   limit_hit <= 1'b1;
  end
`else
  assign ld_val    = rd_val;
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_POSES; p++)
        for (int c = 0; c < NUM_CH; c++)
          tbl_q[p][c] <= ANGLE_W'(HOME_ANGLE);
    end else if (tbl_we) begin
      tbl_q[tbl_pose][tbl_ch] <= tbl_angle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pose_q <= '0;
      step_q <= STEP_W'(1);
      idx_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pose_q <= cmd_pose;
        step_q <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
        idx_q  <= '0;
      end else if (state == ST_LOAD) begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  // A new command in MOVE takes priority over completing the current pose.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (idx_q == CH_W'(NUM_CH - 1)) state_nxt = ST_MOVE;
      end
      ST_MOVE: begin
        busy = 1'b1;
        if (cmd_valid) begin
          state_nxt = ST_LOAD;
        end else if (&at_tgt) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    servo_ch_ramp #(
      .ANGLE_W    (ANGLE_W),
      .STEP_W     (STEP_W),
      .HOME_ANGLE (HOME_ANGLE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (move_tick),
      .step      (step_q),
      .target    (ld_val),
      .load      ((state == ST_LOAD) && (idx_q == CH_W'(k))),
      .angle     (angle[ch_lsb(k, ANGLE_W) +: ANGLE_W]),
      .at_target (at_tgt[k])
    );
  end

endmodule

// File: tb/tb_servo_pose_ramper.sv
// Scoreboard bench for servo_pose_ramper: stimulus pushes the expected final
// angle vector per completed command; a monitor pops and compares on each done.
module tb_servo_pose_ramper;
  import servo_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int ANGLE_W = 8;
  localparam logic [31:0] HOME_VEC = 32'h80808080;
  localparam logic [31:0] POSE3    = {8'd200, 8'd160, 8'd128, 8'd192};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_pose = '0;
  logic [3:0]  cmd_step = '0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_pose = '0;
  logic [1:0]  tbl_ch = '0;
  logic [7:0]  tbl_angle = '0;
  logic [31:0] angle;
  logic        busy, done, limit_hit;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  servo_pose_ramper #(.NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .RAMP_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pose(cmd_pose), .cmd_step(cmd_step), .tbl_we(tbl_we), .tbl_pose(tbl_pose),
    .tbl_ch(tbl_ch), .tbl_angle(tbl_angle), .angle(angle), .busy(busy),
    .done(done), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] ch_ang(input int k);
    return angle[ch_lsb(k, ANGLE_W) +: ANGLE_W];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", angle, 32'hxxxxxxxx);
      end else begin
        check("done_angles", angle, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input int p, input int c, input int v);
    @(negedge clk);
    tbl_we = 1'b1; tbl_pose = 3'(p); tbl_ch = 2'(c); tbl_angle = 8'(v);
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic send_cmd(input int p, input int s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_pose = 3'(p); cmd_step = 4'(s);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    if (busy) check({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ch(input int k, input logic [7:0] v, input string nm);
    int n = 0;
    while (ch_ang(k) != v && n < 1000) begin @(negedge clk); n++; end
    if (ch_ang(k) != v) check({nm, "_timeout"}, 32'(ch_ang(k)), 32'(v));
  endtask

  task automatic wait_ch_change(input int k, input string nm, output logic [7:0] v);
    logic [7:0] start;
    int n = 0;
    start = ch_ang(k);
    while (ch_ang(k) == start && n < 1000) begin @(negedge clk); n++; end
    if (ch_ang(k) == start) check({nm, "_timeout"}, 32'(ch_ang(k)), 32'(start) + 1);
    v = ch_ang(k);
  endtask

  task automatic done_latency(input string nm);
    int lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done && lat == 0) lat = n;
    end
    check(nm, 32'(lat), 32'(NUM_CH + 1));
  endtask

  initial begin
    logic [7:0]  v;
    logic [31:0] snap;
    logic [7:0]  exp0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_angle", angle, HOME_VEC);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_limit", 32'(limit_hit), 32'd0);
    rst = 1'b0;

    wr(3, 0, 192); wr(3, 1, 128); wr(3, 2, 160); wr(3, 3, 200);

    // Step 1 ramp to pose 3; base lands after 64 ticks with the gripper at 192.
    exp_q.push_back(POSE3);
    send_cmd(3, 1);
    @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    check("ready_in_load", 32'(cmd_ready), 32'd0);
    wait_ch(0, 8'd192, "base_192");
    check("grip_at_base_done", 32'(ch_ang(3)), 32'd192);
    check("ch2_at_base_done", 32'(ch_ang(2)), 32'd160);
    wait_idle("pose3_s1");

    exp_q.push_back(HOME_VEC);
    send_cmd(0, 15);
    wait_idle("home_a");

    // Step 0 behaves as step 1.
    exp_q.push_back(POSE3);
    send_cmd(3, 0);
    wait_ch_change(3, "s0_first", v);
    check("step0_first", 32'(v), 32'd129);
    wait_idle("pose3_s0");

    exp_q.push_back(HOME_VEC);
    send_cmd(0, 15);
    wait_idle("home_b");

    // Step 15: 128 -> 143 ... 188 -> 200 (final step 12).
    exp_q.push_back(POSE3);
    send_cmd(3, 15);
    wait_ch_change(3, "s15_first", v);
    check("step15_first", 32'(v), 32'd143);
    wait_ch(3, 8'd188, "s15_188");
    wait_ch_change(3, "s15_last", v);
    check("step15_last", 32'(v), 32'd200);
    wait_idle("pose3_s15");

    // Commanding the current pose completes right after LOAD.
    exp_q.push_back(POSE3);
    send_cmd(3, 1);
    done_latency("same_pose_latency");
    wait_idle("same_pose");

    exp_q.push_back(HOME_VEC);
    send_cmd(0, 15);
    wait_idle("home_c");

    // Retarget mid-MOVE: only the home command may complete.
    send_cmd(3, 1);
    repeat (20) @(negedge clk);
    exp_q.push_back(HOME_VEC);
    send_cmd(0, 1);
    @(negedge clk);
    snap = angle;
    check("retarget_moved", 32'(snap != HOME_VEC), 32'd1);
    repeat (NUM_CH) @(negedge clk);
    check("retarget_hold", angle, snap);
    wait_idle("retarget");

    // Low table value: clamped to 16 only when the limit feature is built in.
`ifdef SERVO_LIMIT_EN
    exp0 = 8'd16;
`else
    exp0 = 8'd10;
`endif
    wr(2, 0, 10);
    exp_q.push_back({8'd128, 8'd128, 8'd128, exp0});
    send_cmd(2, 15);
    wait_idle("limit");
`ifdef SERVO_LIMIT_EN
    check("limit_hit", 32'(limit_hit), 32'd1);
`else
    check("limit_hit", 32'(limit_hit), 32'd0);
`endif

    // Reset mid-MOVE: home angles, table reinitialised, no done.
    send_cmd(3, 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_angle", angle, HOME_VEC);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_limit", 32'(limit_hit), 32'd0);
    rst = 1'b0;
    exp_q.push_back(HOME_VEC);
    send_cmd(3, 1);
    done_latency("table_reinit_latency");
    wait_idle("after_rst");

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
